// File: rtl/rs232_pkg.sv
// Shared register map, status bit positions and FSM state types for the
// rs232_avm_slave Avalon-MM UART bridge.
package rs232_pkg;

  localparam logic [4:0] RX_BASE     = 5'd0;
  localparam logic [4:0] TX_BASE     = 5'd4;
  localparam logic [4:0] STATUS_BASE = 5'd8;

  localparam int unsigned RX_OK_BIT     = 7;
  localparam int unsigned TX_OK_BIT     = 6;
  localparam int unsigned FRAME_ERR_BIT = 5;
  localparam int unsigned OVERRUN_BIT   = 4;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

endpackage

// File: rtl/rs232_rx_deser.sv
// 8N1 receive deserialiser: 2-flop synchroniser, start-bit qualification,
// mid-bit sampling and stop-bit check. Result pulses last one cycle.
module rs232_rx_deser
  import rs232_pkg::*;
#(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       valid,
  output logic       frame_err
);

  logic        rx_s1, rx_s2, rx_s3;
  rx_state_e   state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        stop_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (!rx_s2 && rx_s3) begin
            state <= RX_START;
            cnt   <= 16'(CLK_DIV / 2 - 1);
          end
        end
        RX_START: begin
          if (cnt == '0) begin
            if (rx_s2) begin
              state <= RX_IDLE;
            end else begin
              state   <= RX_DATA;
              cnt     <= 16'(CLK_DIV - 1);
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        RX_DATA: begin
          if (cnt == '0) begin
            shreg   <= {rx_s2, shreg[7:1]};
            cnt     <= 16'(CLK_DIV - 1);
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        RX_STOP: begin
          if (cnt == '0) begin
            state <= RX_IDLE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // Decoded straight from the stop-sample cycle so the store updates on the
  // very next edge, keeping stop-centre to RX_OK at sync depth plus one.
  assign stop_now  = (state == RX_STOP) && (cnt == '0);
  assign valid     = stop_now && rx_s2;
  assign frame_err = stop_now && !rx_s2;
  assign rx_byte   = shreg;

endmodule

// File: rtl/rs232_avm_slave.sv
// Avalon-MM slave exposing an 8N1 UART as RX data / TX data / status registers.
// Define RS232_RX_FIFO_EN for a 4-entry RX FIFO instead of a single holding register.
module rs232_avm_slave
  import rs232_pkg::*;
#(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic        avm_clk,
  input  logic        avm_rst_n,
  input  logic [4:0]  avm_address,
  input  logic        avm_read,
  input  logic        avm_write,
  input  logic [31:0] avm_writedata,
  output logic [31:0] avm_readdata,
  output logic        avm_waitrequest,
  input  logic        uart_rx,
  output logic        uart_tx
);

  logic [7:0]  rx_byte;
  logic        rx_valid, rx_ferr;
  logic        rx_ok, overrun_evt;
  logic [7:0]  rx_head;
  logic        frame_err_q, overrun_q;
  logic [7:0]  status;
  logic        tx_ok;
  logic [7:0]  tx_hold, tx_sh;
  tx_state_e   tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic        pend_pop, pend_wr, pend_clr_fe, pend_clr_ov;
  logic [7:0]  wr_byte;
  logic        commit, do_pop, do_wr, clr_fe, clr_ov;
  logic [23:0] wdata_unused;

  assign wdata_unused = avm_writedata[31:8];

  rs232_rx_deser #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk       (avm_clk),
    .rst_n     (avm_rst_n),
    .rx        (uart_rx),
    .rx_byte   (rx_byte),
    .valid     (rx_valid),
    .frame_err (rx_ferr)
  );

  always_comb begin
    status                = '0;
    status[RX_OK_BIT]     = rx_ok;
    status[TX_OK_BIT]     = tx_ok;
    status[FRAME_ERR_BIT] = frame_err_q;
    status[OVERRUN_BIT]   = overrun_q;
  end

  // Decisions are taken when the request is seen; effects land on the ack edge.
  assign commit = !avm_waitrequest;
  assign do_pop = commit && pend_pop;
  assign do_wr  = commit && pend_wr && tx_ok;
  assign clr_fe = commit && pend_clr_fe;
  assign clr_ov = commit && pend_clr_ov;

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      avm_waitrequest <= 1'b1;
      avm_readdata    <= '0;
      pend_pop        <= 1'b0;
      pend_wr         <= 1'b0;
      pend_clr_fe     <= 1'b0;
      pend_clr_ov     <= 1'b0;
      wr_byte         <= '0;
    end else if (!avm_waitrequest) begin
      avm_waitrequest <= 1'b1;
      avm_readdata    <= '0;
      pend_pop        <= 1'b0;
      pend_wr         <= 1'b0;
      pend_clr_fe     <= 1'b0;
      pend_clr_ov     <= 1'b0;
    end else if (avm_read || avm_write) begin
      avm_waitrequest <= 1'b0;
      avm_readdata    <= '0;
      if (avm_read) begin
        case (avm_address)
          RX_BASE: begin
            if (rx_ok) begin
              avm_readdata <= {24'b0, rx_head};
              pend_pop     <= 1'b1;
            end
          end
          STATUS_BASE: begin
            avm_readdata <= {24'b0, status};
            pend_clr_fe  <= frame_err_q;
            pend_clr_ov  <= overrun_q;
          end
          default: ;
        endcase
      end else if (avm_address == TX_BASE) begin
        pend_wr <= 1'b1;
        wr_byte <= avm_writedata[7:0];
      end
    end
  end

  // A new error on the clearing edge survives the clear.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= (frame_err_q && !clr_fe) || rx_ferr;
      overrun_q   <= (overrun_q && !clr_ov) || overrun_evt;
    end
  end

`ifdef RS232_RX_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] fifo_cnt;
  logic       push;

  assign push        = rx_valid && ((fifo_cnt != 3'd4) || do_pop);
  assign overrun_evt = rx_valid && (fifo_cnt == 3'd4) && !do_pop;
  assign rx_ok       = (fifo_cnt != 3'd0);
  assign rx_head     = fifo_mem[rd_ptr];

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int unsigned i = 0; i < 4; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= rx_byte;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, do_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: ;
      endcase
    end
  end
`else
  logic [7:0] rx_hold;
  logic       rx_hold_valid;

  assign overrun_evt = rx_valid && rx_hold_valid && !do_pop;
  assign rx_ok       = rx_hold_valid;
  assign rx_head     = rx_hold;

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      rx_hold       <= '0;
      rx_hold_valid <= 1'b0;
    end else if (rx_valid && (!rx_hold_valid || do_pop)) begin
      rx_hold       <= rx_byte;
      rx_hold_valid <= 1'b1;
    end else if (do_pop) begin
      rx_hold_valid <= 1'b0;
    end
  end
`endif

  // do_wr needs TX_OK=1 and a load needs TX_OK=0, so they never collide.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_hold  <= '0;
      tx_ok    <= 1'b1;
      uart_tx  <= 1'b1;
    end else begin
      if (do_wr) begin
        tx_hold <= wr_byte;
        tx_ok   <= 1'b0;
      end
      case (tx_state)
        TX_IDLE: begin
          if (!tx_ok) begin
            tx_state <= TX_START;
            tx_sh    <= tx_hold;
            tx_ok    <= 1'b1;
            uart_tx  <= 1'b0;
            tx_cnt   <= 16'(CLK_DIV - 1);
          end
        end
        TX_START: begin
          if (tx_cnt == '0) begin
            tx_state <= TX_DATA;
            uart_tx  <= tx_sh[0];
            tx_bit   <= '0;
            tx_cnt   <= 16'(CLK_DIV - 1);
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= 16'(CLK_DIV - 1);
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              uart_tx  <= 1'b1;
            end else begin
              tx_sh   <= {1'b0, tx_sh[7:1]};
              uart_tx <= tx_sh[1];
              tx_bit  <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == '0) begin
            if (!tx_ok) begin
              tx_state <= TX_START;
              tx_sh    <= tx_hold;
              tx_ok    <= 1'b1;
              uart_tx  <= 1'b0;
              tx_cnt   <= 16'(CLK_DIV - 1);
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_avm_slave.sv
// Directed bench for rs232_avm_slave at CLK_DIV=8 with a queue-based
// register/line model checked every cycle, plus literal spot checks.
module tb_rs232_avm_slave;

`ifdef RS232_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  addr = '0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        wreq;
  logic        urx = 1'b1;
  logic        utx;

  rs232_avm_slave #(.CLK_DIV(8)) dut (
    .avm_clk         (clk),
    .avm_rst_n       (rst_n),
    .avm_address     (addr),
    .avm_read        (rd),
    .avm_write       (wr),
    .avm_writedata   (wdata),
    .avm_readdata    (rdata),
    .avm_waitrequest (wreq),
    .uart_rx         (urx),
    .uart_tx         (utx)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state
  logic [7:0] rxq[$];
  logic       m_fe = 1'b0, m_ov = 1'b0;
  logic       m_hold_full = 1'b0;
  logic [7:0] m_hold = '0;
  logic       txq[$];
  logic       exp_tx = 1'b1;
  logic       exp_wait = 1'b1;
  logic [31:0] exp_rd = '0;
  logic       rec_en = 1'b0;
  logic       rec[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_status();
    return {rxq.size() != 0, !m_hold_full, m_fe, m_ov, 4'b0};
  endfunction

  // Line model: a byte leaves the holding register whenever the line has
  // no frame left to play, producing 10 bits of 8 cycles each.
  always @(posedge clk) begin
    if (!rst_n) begin
      txq.delete();
      m_hold_full = 1'b0;
      exp_tx = 1'b1;
    end else begin
      if (txq.size() == 0 && m_hold_full) begin
        logic [9:0] fr;
        fr = {1'b1, m_hold, 1'b0};
        for (int b = 0; b < 10; b++)
          for (int c = 0; c < 8; c++) txq.push_back(fr[b]);
        m_hold_full = 1'b0;
      end
      exp_tx = (txq.size() != 0) ? txq.pop_front() : 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("uart_tx", {31'b0, utx}, {31'b0, exp_tx});
    chk("waitrequest", {31'b0, wreq}, {31'b0, exp_wait});
    if (!exp_wait) chk("readdata", rdata, exp_rd);
    if (rec_en) rec.push_back(utx);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic is_rd, input logic [4:0] a, input logic [31:0] wd,
                     output logic [31:0] got);
    logic [31:0] e;
    logic pop, clr, accept;
    e = '0; pop = 1'b0; clr = 1'b0;
    if (is_rd) begin
      if (a == 5'd8) begin
        e = {24'b0, m_status()};
        clr = 1'b1;
      end else if (a == 5'd0 && rxq.size() != 0) begin
        e = {24'b0, rxq[0]};
        pop = 1'b1;
      end
    end
    rd = is_rd; wr = !is_rd; addr = a; wdata = wd;
    wait_cyc(1);
    exp_wait = 1'b0;
    exp_rd = e;
    got = rdata;
    accept = !is_rd && (a == 5'd4) && !m_hold_full;
    rd = 1'b0; wr = 1'b0;
    wait_cyc(1);
    exp_wait = 1'b1;
    if (pop) void'(rxq.pop_front());
    if (clr) begin m_fe = 1'b0; m_ov = 1'b0; end
    if (accept) begin m_hold_full = 1'b1; m_hold = wd[7:0]; end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    urx = 1'b0;
    wait_cyc(8);
    for (int i = 0; i < 8; i++) begin
      urx = b[i];
      wait_cyc(8);
    end
    urx = stop;
    wait_cyc(8);
    urx = 1'b1;
    if (stop) begin
      if (rxq.size() < DEPTH) rxq.push_back(b);
      else m_ov = 1'b1;
    end else begin
      m_fe = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] got;
    logic [19:0] pat;
    logic [7:0]  b;
    int f, n;

    // 1. Reset
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(2);
    bus(1'b1, 5'd8, '0, got);
    chk("reset_status", got, 32'h40);
    bus(1'b1, 5'd12, '0, got);
    chk("unmapped_read", got, 32'h0);
    bus(1'b1, 5'd0, '0, got);
    chk("rx_empty_read", got, 32'h0);

    // 2. Single RX byte
    send_frame(8'hA5, 1'b1);
    wait_cyc(4);
    bus(1'b1, 5'd8, '0, got);
    chk("rx_status", got, 32'hC0);
    bus(1'b1, 5'd0, '0, got);
    chk("rx_data", got, 32'hA5);
    bus(1'b1, 5'd8, '0, got);
    chk("rx_status_after", got, 32'h40);

    // 3. TX stream, with a third write discarded while the holder is full
    rec.delete();
    rec_en = 1'b1;
    bus(1'b0, 5'd4, 32'hFFFF_FF3C, got);
    got = '0;
    for (int i = 0; i < 50 && !got[6]; i++) bus(1'b1, 5'd8, '0, got);
    chk("tx_ok_poll", {31'b0, got[6]}, 32'h1);
    bus(1'b0, 5'd4, 32'h81, got);
    bus(1'b0, 5'd4, 32'h77, got);
    wait_cyc(200);
    rec_en = 1'b0;
    pat = 20'b0001111001_0100000011;
    f = -1;
    for (int i = 0; i < rec.size(); i++)
      if (rec[i] == 1'b0) begin f = i; break; end
    if (f < 0 || rec.size() < f + 168) begin
      chk("tx_stream_found", 32'h0, 32'h1);
    end else begin
      for (int k = 0; k < 20; k++) begin
        chk("tx_bit_first", {31'b0, rec[f + 8*k]}, {31'b0, pat[19-k]});
        chk("tx_bit_last", {31'b0, rec[f + 8*k + 7]}, {31'b0, pat[19-k]});
      end
      chk("tx_idle_after", {31'b0, rec[f + 165]}, 32'h1);
    end

    // 4. Overrun
    for (int i = 0; i <= DEPTH; i++) begin
      b = 8'(8'h11 * (i + 1));
      send_frame(b, 1'b1);
    end
    wait_cyc(4);
    bus(1'b1, 5'd8, '0, got);
    chk("ovr_status", got, 32'hD0);
    bus(1'b1, 5'd8, '0, got);
    chk("ovr_status_cleared", got, 32'hC0);
    bus(1'b1, 5'd0, '0, got);
    chk("ovr_first_byte", got, 32'h11);
    for (int i = 1; i < DEPTH; i++) bus(1'b1, 5'd0, '0, got);
    bus(1'b1, 5'd8, '0, got);
    chk("ovr_drained", got, 32'h40);

    // 5. Framing error, then a short glitch
    send_frame(8'h55, 1'b0);
    wait_cyc(4);
    bus(1'b1, 5'd8, '0, got);
    chk("frame_status", got, 32'h60);
    urx = 1'b0;
    wait_cyc(2);
    urx = 1'b1;
    wait_cyc(30);
    bus(1'b1, 5'd8, '0, got);
    chk("glitch_status", got, 32'h40);

    // 6. Reset during TX data bit 4
    bus(1'b0, 5'd4, 32'h00, got);
    n = 0;
    while (utx !== 1'b0 && n < 200) begin
      wait_cyc(1);
      n++;
    end
    chk("tx_fall_seen", {31'b0, utx}, 32'h0);
    wait_cyc(43);
    chk("tx_bit4_low", {31'b0, utx}, 32'h0);
    #2;
    rst_n = 1'b0;
    txq.delete();
    m_hold_full = 1'b0;
    rxq.delete();
    m_fe = 1'b0;
    m_ov = 1'b0;
    exp_tx = 1'b1;
    #1;
    chk("reset_tx_async", {31'b0, utx}, 32'h1);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(2);
    bus(1'b1, 5'd8, '0, got);
    chk("post_reset_status", got, 32'h40);
    wait_cyc(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
